// File: rtl/gba_drawer_vram_responder_pkg.sv
// rtl/gba_drawer_vram_responder_pkg.sv - shared VRAM word geometry and responder state encoding
//
// Purpose: common definitions for the BG drawer VRAM responder.
//   VRAM_ADDR_W    : word address width (16-bit byte space / 4)
//   VRAM_DATA_W    : VRAM word width
//   resp_state_e   : responder FSM states (EMPTY, REQ, WAIT, HOLD)

package gba_drawer_vram_responder_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } resp_state_e;

endpackage

// File: rtl/gba_drawer_vram_responder.sv
// rtl/gba_drawer_vram_responder.sv - fetches the drawer's currently addressed VRAM word from the arbiter
//
// Purpose: the drawer holds a word address and polls VRAM_Drawer_valid; an address change is
// the request. One outstanding read to the VRAM arbiter at a time, tag/data held until the
// address moves, an invalidate pulse arrives, or (optionally) a CPU write hits the tag.
//
// Optional feature: define GBA_VRAM_RESP_SNOOP_EN to snoop CPU VRAM writes (cpu_we/cpu_waddr).
//
// Ports:
//   fclk, reset        : clock, synchronous active-high reset
//   VRAM_Drawer_addr   : word address from the drawer (may change any cycle)
//   VRAM_Drawer_data   : registered word fetched for the tag address
//   VRAM_Drawer_valid  : data corresponds to the current VRAM_Drawer_addr
//   invalidate         : one-cycle pulse, discard held word and refetch
//   mem_req/mem_addr   : arbiter read request (held until mem_gnt), address = tag
//   mem_gnt            : arbiter accepted the request this cycle
//   mem_rvalid/rdata   : read return, one per grant, in order
//   cpu_we/cpu_waddr   : CPU VRAM write snoop (used only with GBA_VRAM_RESP_SNOOP_EN)

module gba_drawer_vram_responder
    import gba_drawer_vram_responder_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] VRAM_Drawer_addr,
    output logic [DATA_W-1:0] VRAM_Drawer_data,
    output logic              VRAM_Drawer_valid,
    input  logic              invalidate,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_waddr
);

    resp_state_e       state_q;
    logic [ADDR_W-1:0] tag_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              stale_q;
    logic              mem_req_q;

    logic addr_match;
    logic snoop_hit;

    assign addr_match = (VRAM_Drawer_addr == tag_q);

`ifdef GBA_VRAM_RESP_SNOOP_EN
    assign snoop_hit = cpu_we & (cpu_waddr == tag_q);
`else
    logic unused_snoop;
    assign unused_snoop = ^{cpu_we, cpu_waddr};
    assign snoop_hit    = 1'b0;
`endif

    // Valid is qualified combinationally so it drops in the very cycle the drawer moves on.
    assign VRAM_Drawer_valid = valid_q & addr_match;
    assign VRAM_Drawer_data  = data_q;
    assign mem_req           = mem_req_q;
    assign mem_addr          = tag_q;

    always_ff @(posedge fclk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            tag_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            stale_q   <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    tag_q     <= VRAM_Drawer_addr;
                    mem_req_q <= 1'b1;
                    state_q   <= ST_REQ;
                end

                ST_REQ: begin
                    if (mem_gnt) begin
                        // Tag freezes at acceptance; it is what the return belongs to.
                        mem_req_q <= 1'b0;
                        stale_q   <= 1'b0;
                        state_q   <= ST_WAIT;
                    end else begin
                        // Not accepted yet: follow the drawer so no stale fetch is issued.
                        tag_q <= VRAM_Drawer_addr;
                    end
                end

                ST_WAIT: begin
                    // Stale is sticky: an address that wanders off and back still refetches.
                    if (!addr_match || invalidate || snoop_hit) begin
                        stale_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        data_q <= mem_rdata;
                        if (!stale_q && !invalidate && !snoop_hit && addr_match) begin
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end else begin
                            valid_q   <= 1'b0;
                            tag_q     <= VRAM_Drawer_addr;
                            mem_req_q <= 1'b1;
                            state_q   <= ST_REQ;
                        end
                    end
                end

                ST_HOLD: begin
                    if (!addr_match) begin
                        valid_q   <= 1'b0;
                        tag_q     <= VRAM_Drawer_addr;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end else if (invalidate || snoop_hit) begin
                        valid_q   <= 1'b0;
                        mem_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end

                default: begin
                    valid_q   <= 1'b0;
                    mem_req_q <= 1'b0;
                    state_q   <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gba_drawer_vram_responder.sv
// tb/tb_gba_drawer_vram_responder.sv - directed self-checking bench for gba_drawer_vram_responder

module tb_gba_drawer_vram_responder;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          fclk = 1'b0;
    logic          reset;
    logic [AW-1:0] VRAM_Drawer_addr;
    logic [DW-1:0] VRAM_Drawer_data;
    logic          VRAM_Drawer_valid;
    logic          invalidate;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          cpu_we;
    logic [AW-1:0] cpu_waddr;

    logic          gnt_en;
    logic          pend_q;
    logic [AW-1:0] paddr_q;
    int            grant_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 fclk = ~fclk;

    gba_drawer_vram_responder dut (
        .fclk              (fclk),
        .reset             (reset),
        .VRAM_Drawer_addr  (VRAM_Drawer_addr),
        .VRAM_Drawer_data  (VRAM_Drawer_data),
        .VRAM_Drawer_valid (VRAM_Drawer_valid),
        .invalidate        (invalidate),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .cpu_we            (cpu_we),
        .cpu_waddr         (cpu_waddr)
    );

    // VRAM contents: word 0x0100 holds 0xDEADBEEF, others differ by their address.
    function automatic logic [DW-1:0] vram_word(input logic [AW-1:0] a);
        return 32'hDEADBEEF ^ {18'd0, a ^ 14'h0100};
    endfunction

    // Arbiter model: immediate grant when enabled, data one cycle after grant.
    assign mem_gnt    = mem_req & gnt_en;
    assign mem_rvalid = pend_q;
    assign mem_rdata  = vram_word(paddr_q);

    always @(posedge fclk) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= mem_gnt;
            if (mem_gnt) begin
                paddr_q     <= mem_addr;
                grant_count <= grant_count + 1;
            end
        end
    end

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; invalidate = 1'b0; cpu_we = 1'b0; cpu_waddr = '0;
        gnt_en = 1'b1; VRAM_Drawer_addr = 14'h0100; grant_count = 0; paddr_q = '0;
        step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", VRAM_Drawer_valid); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
        n_checks++; if (mem_addr !== 14'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        n_checks++; if (VRAM_Drawer_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", VRAM_Drawer_data); end
    endtask

    // Reset released at cycle 0 with addr 0x0100 steady: valid exactly at cycle 3.
    task automatic test_first_fetch();
        reset = 1'b0;
        #1;
        n_checks++; if (VRAM_Drawer_valid !== 1'b0) begin n_fail++; $display("FAIL ff_c0_valid got %b want 0", VRAM_Drawer_valid); end
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0100) begin n_fail++; $display("FAIL ff_c1_req got %b/%h want 1/0100", mem_req, mem_addr); end
        n_checks++; if (VRAM_Drawer_valid !== 1'b0) begin n_fail++; $display("FAIL ff_c1_valid got %b want 0", VRAM_Drawer_valid); end
        step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL ff_c2 got valid %b req %b want 0/0", VRAM_Drawer_valid, mem_req); end
        step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1) begin n_fail++; $display("FAIL ff_c3_valid got %b want 1", VRAM_Drawer_valid); end
        n_checks++; if (VRAM_Drawer_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ff_c3_data got %h want deadbeef", VRAM_Drawer_data); end
        step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || mem_req !== 1'b0 || grant_count !== 1) begin n_fail++; $display("FAIL ff_hold got valid %b req %b grants %0d want 1/0/1", VRAM_Drawer_valid, mem_req, grant_count); end
    endtask

    task automatic test_addr_change();
        VRAM_Drawer_addr = 14'h0101;
        #1;
        n_checks++; if (VRAM_Drawer_valid !== 1'b0) begin n_fail++; $display("FAIL ac_same_cycle_valid got %b want 0", VRAM_Drawer_valid); end
        step();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0101) begin n_fail++; $display("FAIL ac_req got %b/%h want 1/0101", mem_req, mem_addr); end
        step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || VRAM_Drawer_data !== vram_word(14'h0101)) begin n_fail++; $display("FAIL ac_refetch got %b/%h want 1/%h", VRAM_Drawer_valid, VRAM_Drawer_data, vram_word(14'h0101)); end
    endtask

    task automatic test_change_in_wait();
        VRAM_Drawer_addr = 14'h0200;
        step();
        step();
        // Now in WAIT for 0x0200; the return arrives this cycle.
        VRAM_Drawer_addr = 14'h0201;
        #1;
        n_checks++; if (VRAM_Drawer_valid !== 1'b0 || mem_rvalid !== 1'b1) begin n_fail++; $display("FAIL cw_wait got valid %b rvalid %b want 0/1", VRAM_Drawer_valid, mem_rvalid); end
        step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b0) begin n_fail++; $display("FAIL cw_first_not_valid got %b want 0", VRAM_Drawer_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0201) begin n_fail++; $display("FAIL cw_second_req got %b/%h want 1/0201", mem_req, mem_addr); end
        step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || VRAM_Drawer_data !== vram_word(14'h0201)) begin n_fail++; $display("FAIL cw_second_data got %b/%h want 1/%h", VRAM_Drawer_valid, VRAM_Drawer_data, vram_word(14'h0201)); end
    endtask

    task automatic test_grant_stall();
        int g0;
        g0 = grant_count;
        gnt_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            VRAM_Drawer_addr = 14'h0010 + 14'(i);
            step();
        end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0014 || grant_count !== g0) begin n_fail++; $display("FAIL gs_stalled got req %b addr %h grants %0d want 1/0014/%0d", mem_req, mem_addr, grant_count, g0); end
        gnt_en = 1'b1;
        step();
        n_checks++; if (grant_count !== g0 + 1 || paddr_q !== 14'h0014) begin n_fail++; $display("FAIL gs_grant got %0d/%h want %0d/0014", grant_count, paddr_q, g0 + 1); end
        step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || VRAM_Drawer_data !== vram_word(14'h0014) || grant_count !== g0 + 1) begin n_fail++; $display("FAIL gs_valid got %b/%h/%0d want 1/%h/%0d", VRAM_Drawer_valid, VRAM_Drawer_data, grant_count, vram_word(14'h0014), g0 + 1); end
    endtask

    task automatic test_invalidate_on_rvalid();
        VRAM_Drawer_addr = 14'h0030;
        step(); step();
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        n_checks++; if (VRAM_Drawer_valid !== 1'b0 || VRAM_Drawer_data !== vram_word(14'h0030)) begin n_fail++; $display("FAIL inv_capture got %b/%h want 0/%h", VRAM_Drawer_valid, VRAM_Drawer_data, vram_word(14'h0030)); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0030) begin n_fail++; $display("FAIL inv_refetch got %b/%h want 1/0030", mem_req, mem_addr); end
        step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1) begin n_fail++; $display("FAIL inv_valid_after got %b want 1", VRAM_Drawer_valid); end
    endtask

    task automatic test_reset_mid_wait();
        VRAM_Drawer_addr = 14'h0040;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++; if (VRAM_Drawer_valid !== 1'b0 || mem_req !== 1'b0 || VRAM_Drawer_data !== 32'h0) begin n_fail++; $display("FAIL rw_reset got %b/%b/%h want 0/0/0", VRAM_Drawer_valid, mem_req, VRAM_Drawer_data); end
        step(); step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || VRAM_Drawer_data !== vram_word(14'h0040)) begin n_fail++; $display("FAIL rw_refetch got %b/%h want 1/%h", VRAM_Drawer_valid, VRAM_Drawer_data, vram_word(14'h0040)); end
    endtask

    task automatic test_snoop();
        VRAM_Drawer_addr = 14'h0300;
        step(); step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1) begin n_fail++; $display("FAIL sn_hold got %b want 1", VRAM_Drawer_valid); end
        cpu_we = 1'b1; cpu_waddr = 14'h0301;
        step();
        cpu_we = 1'b0;
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL sn_miss got %b/%b want 1/0", VRAM_Drawer_valid, mem_req); end
        cpu_we = 1'b1; cpu_waddr = 14'h0300;
        step();
        cpu_we = 1'b0;
`ifdef GBA_VRAM_RESP_SNOOP_EN
        n_checks++; if (VRAM_Drawer_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 14'h0300) begin n_fail++; $display("FAIL sn_hit got %b/%b/%h want 0/1/0300", VRAM_Drawer_valid, mem_req, mem_addr); end
        step(); step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1) begin n_fail++; $display("FAIL sn_refetch got %b want 1", VRAM_Drawer_valid); end
`else
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL sn_ignored got %b/%b want 1/0", VRAM_Drawer_valid, mem_req); end
        step();
        n_checks++; if (VRAM_Drawer_valid !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL sn_ignored2 got %b/%b want 1/0", VRAM_Drawer_valid, mem_req); end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_addr_change();
        test_change_in_wait();
        test_grant_stall();
        test_invalidate_on_rvalid();
        test_reset_mid_wait();
        test_snoop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
